// File: rtl/fp_div_iter.sv
// Sequential decimal floating-point divider: bit-serial restoring division of a decimally
// pre-scaled numerator, then decimal normalisation with optional round-half-up.
module fp_div_iter #(
    parameter int unsigned MANT_W      = 34,
    parameter int unsigned EXP_W       = 7,
    parameter int unsigned FRAC_DIGITS = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    eval,
    input  logic                    roundMode,
    input  logic                    signA,
    input  logic                    signB,
    input  logic [MANT_W-1:0]       mantA,
    input  logic [MANT_W-1:0]       mantB,
    input  logic signed [EXP_W-1:0] expA,
    input  logic signed [EXP_W-1:0] expB,
    output logic                    busy,
    output logic                    done,
    output logic                    signRes,
    output logic [MANT_W-1:0]       mantRes,
    output logic [EXP_W-1:0]        expRes,
    output logic                    divByZero,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    zeroRes
);

    localparam int unsigned NUM_W  = MANT_W + 4 * FRAC_DIGITS;
    localparam int unsigned IEXP_W = EXP_W + 4;
    localparam int unsigned CNT_W  = $clog2(NUM_W);
    localparam int EXP_MAX_I = 2 ** (EXP_W - 1) - 1;
    localparam int EXP_MIN_I = -(2 ** (EXP_W - 1));

    localparam logic [MANT_W-1:0] MANT_MAX   = '1;
    localparam logic [NUM_W-1:0]  MANT_MAX_N = {{(NUM_W - MANT_W){1'b0}}, {MANT_W{1'b1}}};
    localparam logic [EXP_W-1:0]  EXP_MAX_O  = {1'b0, {(EXP_W - 1){1'b1}}};
    localparam logic signed [IEXP_W-1:0] IEXP_MAX = IEXP_W'(EXP_MAX_I);
    localparam logic signed [IEXP_W-1:0] IEXP_MIN = IEXP_W'(EXP_MIN_I);

    function automatic logic [NUM_W-1:0] pow10(input int unsigned n);
        logic [NUM_W-1:0] p;
        p = NUM_W'(1);
        for (int unsigned i = 0; i < n; i++) p = p * NUM_W'(10);
        return p;
    endfunction

    localparam logic [NUM_W-1:0] SCALE = pow10(FRAC_DIGITS);

    typedef enum logic [2:0] {StIdle, StPrep, StDiv, StNorm, StRound, StDone} state_t;

    state_t state, stateNext;

    logic                     evalPrev;
    logic                     doEval;
    logic                     signL;
    logic                     roundModeL;
    logic [MANT_W-1:0]        mantAL;
    logic [MANT_W-1:0]        mantBL;
    logic signed [EXP_W-1:0]  expAL;
    logic signed [EXP_W-1:0]  expBL;
    logic [NUM_W-1:0]         q;
    logic [MANT_W:0]          rem;
    logic [CNT_W-1:0]         cnt;
    logic signed [IEXP_W-1:0] iexp;
    logic [3:0]               lastDigit;
    logic                     sticky;

    logic [MANT_W:0]  remShift;
    logic             remGe;
    logic [MANT_W:0]  remNext;
    logic             qBig;
    logic             roundUp;
    logic [NUM_W-1:0] qRnd;
    logic             rndBig;

    assign doEval = eval & ~evalPrev;

    always_comb begin
        remShift = {rem[MANT_W-1:0], q[NUM_W-1]};
        remGe    = remShift >= {1'b0, mantBL};
        remNext  = remGe ? remShift - {1'b0, mantBL} : remShift;
        qBig     = q > MANT_MAX_N;
        roundUp  = roundModeL && (lastDigit >= 4'd5);
        qRnd     = q + NUM_W'(roundUp);
        rndBig   = qRnd > MANT_MAX_N;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            StIdle:  if (doEval) stateNext = (mantB == '0) ? StDone : StPrep;
            StPrep:  stateNext = StDiv;
            StDiv:   if (cnt == '0) stateNext = StNorm;
            StNorm:  if (!qBig) stateNext = StRound;
            StRound: stateNext = rndBig ? StNorm : StDone;
            StDone:  stateNext = StIdle;
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= StIdle;
        else       state <= stateNext;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            evalPrev   <= 1'b0;
            signL      <= 1'b0;
            roundModeL <= 1'b0;
            mantAL     <= '0;
            mantBL     <= '0;
            expAL      <= '0;
            expBL      <= '0;
            q          <= '0;
            rem        <= '0;
            cnt        <= '0;
            iexp       <= '0;
            lastDigit  <= '0;
            sticky     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            signRes    <= 1'b0;
            mantRes    <= '0;
            expRes     <= '0;
            divByZero  <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            zeroRes    <= 1'b0;
        end else begin
            evalPrev <= eval;
            done     <= (state == StDone);
            unique case (state)
                StIdle: begin
                    if (doEval) begin
                        signL      <= signA ^ signB;
                        roundModeL <= roundMode;
                        mantAL     <= mantA;
                        mantBL     <= mantB;
                        expAL      <= expA;
                        expBL      <= expB;
                        busy       <= 1'b1;
                        divByZero  <= 1'b0;
                        overflow   <= 1'b0;
                        underflow  <= 1'b0;
                        zeroRes    <= 1'b0;
                        if (mantB == '0) begin
                            signRes   <= signA ^ signB;
                            mantRes   <= MANT_MAX;
                            expRes    <= EXP_MAX_O;
                            divByZero <= 1'b1;
                        end
                    end
                end
                StPrep: begin
                    q         <= NUM_W'(mantAL) * SCALE;
                    rem       <= '0;
                    iexp      <= $signed(IEXP_W'(expAL)) - $signed(IEXP_W'(expBL))
                                 - $signed(IEXP_W'(FRAC_DIGITS));
                    sticky    <= 1'b0;
                    lastDigit <= '0;
                    cnt       <= CNT_W'(NUM_W - 1);
                end
                StDiv: begin
                    // Dividend bits shift out of q's MSB while quotient bits shift in at the LSB.
                    rem <= remNext;
                    q   <= {q[NUM_W-2:0], remGe};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) sticky <= sticky | (remNext != '0);
                end
                StNorm: begin
                    if (qBig) begin
                        sticky    <= sticky | (lastDigit != '0);
                        lastDigit <= 4'(q % NUM_W'(10));
                        q         <= q / NUM_W'(10);
                        iexp      <= iexp + IEXP_W'(1);
                    end
                end
                StRound: begin
                    if (rndBig) begin
                        q         <= qRnd;
                        lastDigit <= '0;
                    end else begin
                        signRes <= signL;
                        if (qRnd == '0) begin
                            mantRes <= '0;
                            expRes  <= '0;
                            zeroRes <= 1'b1;
                        end else if (iexp > IEXP_MAX) begin
                            mantRes  <= MANT_MAX;
                            expRes   <= EXP_MAX_O;
                            overflow <= 1'b1;
                        end else if (iexp < IEXP_MIN) begin
                            mantRes   <= '0;
                            expRes    <= '0;
                            underflow <= 1'b1;
                            zeroRes   <= 1'b1;
                        end else begin
                            mantRes <= qRnd[MANT_W-1:0];
                            expRes  <= iexp[EXP_W-1:0];
                        end
                    end
                end
                StDone: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fp_div_iter.md
# fp_div_iter

Parametrised sequential decimal floating-point divider for the calculator datapath. It computes `(signA, mantA, expA) / (signB, mantB, expB)` over the shared value format `(-1)^sign × mant × 10^exp`. It uses a bit-serial restoring division with a configurable number of fractional decimal digits, then decimal normalisation with selectable truncate or round-half-up. It flags divide-by-zero, exponent overflow, exponent underflow and zero results, and sits beside the adder and multiplier behind the same eval/done handshake.

## Interface
Parameters:
- MANT_W, 34: mantissa width. MANT_MAX = 2^MANT_W − 1.
- EXP_W, 7: signed exponent width. EXP_MAX = 2^(EXP_W−1) − 1, EXP_MIN = −2^(EXP_W−1).
- FRAC_DIGITS, 12: decimal pre-scale of the numerator (10^FRAC_DIGITS).
- Derived, local: NUM_W = MANT_W + 4·FRAC_DIGITS (dividend and quotient width); IEXP_W = EXP_W + 4 (internal signed exponent width).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- eval  in  1  start request, level; a rising edge is detected internally.
- roundMode  in  1  0 = truncate, 1 = round half up.
- signA, signB  in  1  operand signs.
- mantA, mantB  in  MANT_W  unsigned operand mantissas.
- expA, expB  in  EXP_W  signed operand exponents.
- busy  out  1  high from the capture edge until done.
- done  out  1  one-cycle completion pulse.
- signRes  out  1  result sign.
- mantRes  out  MANT_W  result mantissa.
- expRes  out  EXP_W  signed result exponent.
- divByZero, overflow, underflow, zeroRes  out  1 each  status flags, valid while done is high and held until the next capture.

## Operation
- Start: doEval = eval & ~evalPrev. evalPrev is registered every cycle and resets to 0. doEval is honoured only in IDLE and is ignored while busy. Operands are sampled only on the capture edge (E0).
- S_IDLE: on doEval, latch the operands and set sign = signA ^ signB. Branch on mantB:
  - mantB == 0: write mantRes = MANT_MAX, expRes = EXP_MAX, divByZero = 1, other flags 0, then go to S_DONE.
  - Otherwise go to S_PREP.
- S_PREP: dividend = mantA × 10^FRAC_DIGITS (NUM_W bits). iexp = expA − expB − FRAC_DIGITS (IEXP_W bits). Clear the sticky bit. Go to S_DIV with the bit counter set to NUM_W−1.
- S_DIV: restoring radix-2 division, one quotient bit per edge, MSB first, remainder width MANT_W+1. On the edge where the counter reaches 0, sticky |= (remainder ≠ 0) and the state moves to S_NORM.
- S_NORM: if q > MANT_MAX, then:
  - sticky |= (lastDigit ≠ 0);
  - lastDigit = q % 10;
  - q = q / 10;
  - iexp += 1.
  Otherwise go to S_ROUND. lastDigit is cleared at S_PREP.
- S_ROUND: with roundMode = 1 and lastDigit ≥ 5, q += 1; if that gives q > MANT_MAX, clear lastDigit and return to S_NORM. Otherwise select exactly one of the following, checked in this order, then go to S_DONE:
  - q == 0: mantRes = 0, expRes = 0, zeroRes = 1.
  - iexp > EXP_MAX: mantRes = MANT_MAX, expRes = EXP_MAX, overflow = 1.
  - iexp < EXP_MIN: mantRes = 0, expRes = 0, underflow = 1, zeroRes = 1.
  - Else: mantRes = q, expRes = iexp.
- S_DONE: assert done for one cycle, deassert busy, go to S_IDLE.
- signRes is the XOR sign in all cases, including zero results.
- Reset, including mid-operation: all outputs and flags go to 0, the state returns to S_IDLE, evalPrev = 0 and intermediate registers clear. No done pulse is produced for an aborted operation. If eval is high when reset releases, it is treated as a fresh edge.

## Timing
- E0 = capture edge. busy rises after E0.
- Normal path:
  - E1 is PREP.
  - E2 through E(NUM_W+1) are DIV.
  - k normalising edges follow, plus 1 exit edge.
  - ROUND is at E(NUM_W+k+3), DONE at E(NUM_W+k+4).
  - done is high for the cycle after the DONE edge. Default NUM_W = 82.
- A rounding carry back into S_NORM adds 2 edges.
- Divide-by-zero path: E0 writes the outputs, E1 is DONE, done is high after E1.
- Result outputs update on the ROUND edge (E0 on the divide-by-zero path), one cycle before done rises.
- Back-to-back operation: a new eval edge is accepted in the cycle done is high, because the state is IDLE.

## Test plan
- mantA=1, expA=0, mantB=1, expB=0 → mantRes=10000000000, expRes=−10, signRes=0, k=2, done one cycle after E88.
- mantA=2, mantB=3, exps 0, signA=1 → roundMode=1 gives mantRes=6666666667; roundMode=0 gives 6666666666; expRes=−10 and signRes=1 in both.
- mantB=0 → divByZero=1, mantRes=MANT_MAX, expRes=63, done high after E1.
- expA=63, expB=−64, mantA=mantB=1 → overflow=1, mantRes=MANT_MAX, expRes=63. expA=−64, expB=63 → underflow=1, zeroRes=1, mantRes=0, expRes=0.
- mantA=0, mantB=5 → zeroRes=1, mantRes=0, expRes=0.
- eval re-pulsed mid-DIV → ignored and the result is unchanged. Reset asserted mid-DIV → outputs 0 and no done pulse. eval held high across reset release → a new operation starts.
